// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dmem_state_t;

  localparam int DMEM_TIMEOUT_DEFAULT = 255;
  localparam int DMEM_ALIGN_BITS      = 3;
  localparam int DMEM_N_DEFAULT       = 64;

  // Doubleword alignment: low address bits must be zero.
  function automatic logic is_aligned(input logic [DMEM_ALIGN_BITS-1:0] lsb);
    return lsb == '0;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Valid/ready memory bus between the controller (master) and memory (slave).
interface dmem_ctrl_if
  import dmem_pkg::*;
#(
  parameter int N = DMEM_N_DEFAULT
);
  logic         bus_req_valid;
  logic         bus_req_ready;
  logic         bus_we;
  logic [N-1:0] bus_addr;
  logic [N-1:0] bus_wdata;
  logic         bus_rsp_valid;
  logic [N-1:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_we, bus_addr, bus_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_we, bus_addr, bus_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: turns the datapath request into a bus
// transaction, stalls the pipeline until it completes, flags misalign/timeout.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int N       = DMEM_N_DEFAULT,
  parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  DM_addr,
  input  logic [N-1:0]  DM_writeData,
  input  logic          DM_writeEnable,
  input  logic          DM_readEnable,
  output logic [N-1:0]  DM_readData,
  output logic          stall,
  output logic          misalign_err,
  output logic          timeout_err,
  dmem_ctrl_if.master   bus
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  dmem_state_t   r_state, w_next;
  logic [N-1:0]  r_addr, r_wdata, r_rdata;
  logic          r_we, r_mis, r_to;
  logic [CW-1:0] r_cnt;

  logic w_pending, w_aligned;
  logic w_start, w_misalign, w_hs, w_rsp, w_tmo;

  assign w_pending = DM_writeEnable | DM_readEnable;
  assign w_aligned = is_aligned(DM_addr[DMEM_ALIGN_BITS-1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_misalign = 1'b0;
    w_hs       = 1'b0;
    w_rsp      = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pending && w_aligned) begin
          w_start = 1'b1;
          w_next  = REQ;
        end else if (w_pending) begin
          w_misalign = 1'b1;
        end
      end
      REQ: begin
        if (bus.bus_req_ready) begin
          w_hs   = 1'b1;
          w_next = WAIT;
        end
      end
      WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (bus.bus_rsp_valid) begin
          w_rsp  = 1'b1;
          w_next = DONE;
        end else if (r_cnt == CNT_MAX) begin
          w_tmo  = 1'b1;
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_mis   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= DM_addr;
        r_wdata <= DM_writeData;
        r_we    <= DM_writeEnable;
      end
      if (w_hs)
        r_cnt <= '0;
      else if (r_state == WAIT && r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CW'(1);
      if (w_rsp)
        r_rdata <= r_we ? '0 : bus.bus_rdata;
      else if (w_tmo)
        r_rdata <= '0;
      if (w_misalign) r_mis <= 1'b1;
      if (w_tmo)      r_to  <= 1'b1;
    end
  end

  // Gated by reset so stall drops asynchronously even with a request held.
  assign stall = reset & (w_start | (r_state == REQ) | (r_state == WAIT));

  assign DM_readData  = (r_state == DONE) ? r_rdata : '0;
  assign misalign_err = r_mis;
  assign timeout_err  = r_to;

  assign bus.bus_req_valid = (r_state == REQ);
  assign bus.bus_we        = r_we;
  assign bus.bus_addr      = r_addr;
  assign bus.bus_wdata     = r_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed table-driven bench for dmem_ctrl with a small reactive bus model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int N   = 64;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] DM_addr = '0;
  logic [N-1:0] DM_writeData = '0;
  logic         DM_writeEnable = 1'b0;
  logic         DM_readEnable = 1'b0;
  logic [N-1:0] DM_readData;
  logic         stall, misalign_err, timeout_err;

  dmem_ctrl_if #(.N(N)) bus ();

  dmem_ctrl #(.N(N), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .DM_readEnable  (DM_readEnable),
    .DM_readData    (DM_readData),
    .stall          (stall),
    .misalign_err   (misalign_err),
    .timeout_err    (timeout_err),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we, re;
    logic [63:0] addr, wdata, rdata;
    int          rdly, rsp;           // ready delay; response delay after handshake (0 = never)
    int          e_stalls;
    logic [63:0] e_rd;
    int          e_reqs, e_vcyc;
    logic        e_we;
    int          e_h2d;               // handshake-to-DONE cycles, -1 if no handshake
    logic        e_mis, e_to;
  } vec_t;

  vec_t vecs[10];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic run_txn(input vec_t v, output int stalls, output logic [63:0] rd,
                         output int reqs, output int vcyc, output logic we_seen,
                         output int h2d, output logic stable, output logic done);
    logic prev_v;
    int   hs_cyc;
    stalls = 0; rd = '0; reqs = 0; vcyc = 0; we_seen = 1'b0;
    h2d = -1; stable = 1'b1; done = 1'b0; prev_v = 1'b0; hs_cyc = -1;
    @(negedge clk);
    DM_addr = v.addr; DM_writeData = v.wdata;
    DM_writeEnable = v.we; DM_readEnable = v.re;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (bus.bus_req_valid) begin
        if (!prev_v) reqs++;
        if (bus.bus_addr !== v.addr || bus.bus_wdata !== v.wdata) stable = 1'b0;
        we_seen = bus.bus_we;
        bus.bus_req_ready = (vcyc >= v.rdly);
        vcyc++;
        if (bus.bus_req_ready) hs_cyc = cyc;
      end else begin
        bus.bus_req_ready = 1'b0;
      end
      prev_v = bus.bus_req_valid;
      bus.bus_rsp_valid = (hs_cyc >= 0 && v.rsp > 0 && cyc == hs_cyc + v.rsp);
      bus.bus_rdata = v.rdata;
      #1;
      if (!stall) begin
        rd = DM_readData;
        done = 1'b1;
        if (hs_cyc >= 0) h2d = cyc - hs_cyc;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    int stalls, reqs, vcyc, h2d;
    logic [63:0] rd;
    logic we_seen, stable, done;
    run_txn(v, stalls, rd, reqs, vcyc, we_seen, h2d, stable, done);
    chk ($sformatf("v%0d_done", idx), done, 1'b1);
    chki($sformatf("v%0d_stall_cycles", idx), stalls, v.e_stalls);
    chk ($sformatf("v%0d_readData", idx), rd, v.e_rd);
    chki($sformatf("v%0d_req_pulses", idx), reqs, v.e_reqs);
    chki($sformatf("v%0d_valid_cycles", idx), vcyc, v.e_vcyc);
    chk ($sformatf("v%0d_bus_we", idx), we_seen, v.e_we);
    chki($sformatf("v%0d_hs_to_done", idx), h2d, v.e_h2d);
    chk ($sformatf("v%0d_fields_stable", idx), stable, 1'b1);
    @(posedge clk); #1;
    chk ($sformatf("v%0d_misalign_err", idx), misalign_err, v.e_mis);
    chk ($sformatf("v%0d_timeout_err", idx), timeout_err, v.e_to);
    chk ($sformatf("v%0d_idle_no_req", idx), bus.bus_req_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we    re    addr   wdata  rdata                  rdly rsp stl e_rd                   rq vc we    h2d mis   to
    vecs[0] = '{1'b0, 1'b1, 64'h10, 64'h0,  64'hDEADBEEF,          0,   1,  3, 64'hDEADBEEF,          1, 1, 1'b0, 2,  1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 64'h20, 64'h55, 64'hFFFFFFFFFFFFFFFF,  4,   1,  7, 64'h0,                 1, 5, 1'b1, 2,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 64'h40, 64'h0,  64'h0123456789ABCDEF,  2,   3,  7, 64'h0123456789ABCDEF,  1, 3, 1'b0, 4,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 64'h13, 64'h0,  64'h5A,                0,   1,  0, 64'h0,                 0, 0, 1'b0, -1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 64'h18, 64'h0,  64'h77,                0,   1,  3, 64'h77,                1, 1, 1'b0, 2,  1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 64'h30, 64'hAA, 64'h1234,              0,   1,  3, 64'h0,                 1, 1, 1'b1, 2,  1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 64'h50, 64'h0,  64'hEE,                0,   0, 11, 64'h0,                 1, 1, 1'b0, 10, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 64'h58, 64'h0,  64'h99,                0,   1,  3, 64'h99,                1, 1, 1'b0, 2,  1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 64'h24, 64'h11, 64'h0,                 0,   1,  0, 64'h0,                 0, 0, 1'b0, -1, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 64'h8,  64'h0,  64'hC0FFEE,            0,   1,  3, 64'hC0FFEE,            1, 1, 1'b0, 2,  1'b0, 1'b0};

    bus.bus_req_ready = 1'b0;
    bus.bus_rsp_valid = 1'b0;
    bus.bus_rdata     = '0;

    // Reset state, with an aligned load held on the inputs.
    DM_addr = 64'h8; DM_readEnable = 1'b1;
    #12;
    chk("rst_stall", stall, 1'b0);
    chk("rst_req_valid", bus.bus_req_valid, 1'b0);
    chk("rst_bus_we", bus.bus_we, 1'b0);
    chk("rst_bus_addr", bus.bus_addr, 64'h0);
    chk("rst_bus_wdata", bus.bus_wdata, 64'h0);
    chk("rst_readData", DM_readData, 64'h0);
    chk("rst_misalign", misalign_err, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    @(negedge clk);
    DM_readEnable = 1'b0; DM_addr = '0;
    reset = 1'b1;

    for (int i = 0; i < 9; i++) check_vec(vecs[i], i);

    // Reset asserted while WAITing on a response that never comes in time.
    @(negedge clk);
    DM_addr = 64'h60; DM_writeData = 64'h33; DM_readEnable = 1'b1; DM_writeEnable = 1'b0;
    bus.bus_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("wait_stall", stall, 1'b1);
    chk("wait_req_valid", bus.bus_req_valid, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_stall", stall, 1'b0);
    chk("arst_req_valid", bus.bus_req_valid, 1'b0);
    chk("arst_bus_addr", bus.bus_addr, 64'h0);
    chk("arst_bus_wdata", bus.bus_wdata, 64'h0);
    chk("arst_readData", DM_readData, 64'h0);
    chk("arst_misalign", misalign_err, 1'b0);
    chk("arst_timeout", timeout_err, 1'b0);
    @(negedge clk);
    DM_readEnable = 1'b0; DM_addr = '0;
    bus.bus_req_ready = 1'b0;
    reset = 1'b1;
    bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 64'hBAD;
    @(posedge clk); #1;
    chk("late_rsp_stall", stall, 1'b0);
    chk("late_rsp_readData", DM_readData, 64'h0);
    chk("late_rsp_req_valid", bus.bus_req_valid, 1'b0);
    @(negedge clk);
    bus.bus_rsp_valid = 1'b0;

    check_vec(vecs[9], 9);

    @(negedge clk);
    DM_readEnable = 1'b0; DM_writeEnable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
